microwave_sequencer: RTL and testbench

Cook-cycle controller for the microwave oven. It takes debounced keypad digits, the once-per-second timer pulse and the door/start/stop inputs. It holds the programmed time as four BCD digits (mm:ss), counts it down while cooking and drives the magnetron enable and the end-of-cycle beep. It sits between the keypad encoder / clock-divider front end and the display and power stage.

---
 rtl/microondas_pkg.sv | 17 +
 rtl/bcd_mmss_decrement.sv | 33 +++
 rtl/microwave_sequencer.sv | 118 +++++++++++
 tb/tb_microwave_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/microondas_pkg.sv
// Shared constants for the microwave cook-cycle controller: state encodings
// and the BCD mm:ss field geometry.
package microondas_pkg;

    localparam int BCD_W  = 4;
    localparam int TIME_W = 16;

    // Largest legal seconds-tens digit; also the reload value on a borrow.
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_COOK  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/bcd_mmss_decrement.sv
// Combinational one-second decrement of a {min_tens, min_ones, sec_tens, sec_ones}
// BCD field, plus a zero flag for the incoming value.
module bcd_mmss_decrement
    import microondas_pkg::*;
(
    input  logic [TIME_W-1:0] cur,
    output logic [TIME_W-1:0] next,
    output logic              zero
);

    always_comb begin
        next = cur;
        zero = (cur == '0);
        if (cur[3:0] != 4'd0) begin
            next[3:0] = cur[3:0] - 4'd1;
        end else begin
            next[3:0] = 4'd9;
            if (cur[7:4] != 4'd0) begin
                next[7:4] = cur[7:4] - 4'd1;
            end else begin
                next[7:4] = SEC_TENS_MAX;
                if (cur[11:8] != 4'd0) begin
                    next[11:8] = cur[11:8] - 4'd1;
                end else begin
                    next[11:8]  = 4'd9;
                    // Only reachable from 00:00, which the controller never decrements.
                    next[15:12] = (cur[15:12] != 4'd0) ? cur[15:12] - 4'd1 : 4'd9;
                end
            end
        end
    end

endmodule

// File: rtl/microwave_sequencer.sv
// Cook-cycle controller: keypad time entry, BCD countdown while cooking,
// pause/resume on door or stop, and a timed end-of-cycle beep.
module microwave_sequencer
    import microondas_pkg::*;
#(
    parameter int DONE_TICKS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              start,
    input  logic              stop_clear,
    input  logic              door_closed,
    input  logic              sec_tick,
    output logic [TIME_W-1:0] time_bcd,
    output logic              mag_on,
    output logic              done_beep,
    output logic [2:0]        state_o
);

    localparam int CNT_W = $clog2(DONE_TICKS + 1);

    logic [2:0]        state, state_nx;
    logic [TIME_W-1:0] time_nx, dec_next, clamped;
    logic              dec_zero, key_digit;
    logic [CNT_W-1:0]  beep_cnt, beep_nx;

    bcd_mmss_decrement u_dec (
        .cur  (time_bcd),
        .next (dec_next),
        .zero (dec_zero)
    );

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign clamped   = (time_bcd[7:4] > SEC_TENS_MAX) ? {time_bcd[15:8], 8'h59} : time_bcd;
    assign state_o   = state;

    always_comb begin
        state_nx = state;
        time_nx  = time_bcd;
        beep_nx  = beep_cnt;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (stop_clear) begin
                    state_nx = ST_IDLE;
                    time_nx  = '0;
                end else if (start) begin
                    // A start that is refused still outranks a same-cycle key.
                    if (door_closed && time_bcd != '0) begin
                        state_nx = ST_COOK;
                        time_nx  = clamped;
                    end
                end else if (key_digit) begin
                    state_nx = ST_ENTRY;
                    time_nx  = {time_bcd[11:0], key_code};
                end
            end
            ST_COOK: begin
                if (stop_clear || !door_closed) begin
                    state_nx = ST_PAUSE;
                end else if (sec_tick) begin
                    time_nx = dec_next;
                    if (dec_next == '0 || dec_zero) begin
                        state_nx = ST_DONE;
                        time_nx  = '0;
                        beep_nx  = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    state_nx = ST_IDLE;
                    time_nx  = '0;
                end else if (start && door_closed) begin
                    state_nx = ST_COOK;
                end
            end
            ST_DONE: begin
                time_nx = '0;
                if (stop_clear || key_valid) begin
                    state_nx = ST_IDLE;
                    beep_nx  = '0;
                end else if (sec_tick) begin
                    if (beep_cnt == CNT_W'(DONE_TICKS - 1)) begin
                        state_nx = ST_IDLE;
                        beep_nx  = '0;
                    end else begin
                        beep_nx = beep_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                time_nx  = '0;
                beep_nx  = '0;
            end
        endcase
    end

    // Output flags are decoded from the next state so they move with state_o.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            time_bcd  <= '0;
            beep_cnt  <= '0;
            mag_on    <= 1'b0;
            done_beep <= 1'b0;
        end else begin
            state     <= state_nx;
            time_bcd  <= time_nx;
            beep_cnt  <= beep_nx;
            mag_on    <= (state_nx == ST_COOK);
            done_beep <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: tb/tb_microwave_sequencer.sv
// Directed test-plan steps followed by random keypad/door/tick traffic, all
// compared each cycle against a seconds-based reference model.
module tb_microwave_sequencer;

    logic        clock = 1'b0;
    logic        reset, key_valid, start, stop_clear, door_closed, sec_tick;
    logic [3:0]  key_code;
    logic [15:0] time_bcd;
    logic        mag_on, done_beep;
    logic [2:0]  state_o;

    int checks   = 0;
    int failures = 0;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

    // Model: entered digits while programming, total seconds while cooking.
    int m_state;
    int m_dig[4];
    int m_tot;
    int m_beeps;

    microwave_sequencer #(.DONE_TICKS(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .sec_tick    (sec_tick),
        .time_bcd    (time_bcd),
        .mag_on      (mag_on),
        .done_beep   (done_beep),
        .state_o     (state_o)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int tot);
        int m, s;
        m = tot / 60;
        s = tot % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] exp_time();
        if (m_state == M_IDLE || m_state == M_ENTRY)
            return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
        if (m_state == M_COOK || m_state == M_PAUSE)
            return to_bcd(m_tot);
        return 16'h0000;
    endfunction

    task automatic clear_digits();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endtask

    task automatic model_step();
        int sec;
        if (reset) begin
            m_state = M_IDLE; clear_digits(); m_tot = 0; m_beeps = 0;
            return;
        end
        case (m_state)
            M_IDLE, M_ENTRY: begin
                if (stop_clear) begin
                    m_state = M_IDLE; clear_digits();
                end else if (start) begin
                    if (door_closed && (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3]) != 0) begin
                        sec = m_dig[1] * 10 + m_dig[0];
                        if (sec > 59) sec = 59;
                        m_tot   = (m_dig[3] * 10 + m_dig[2]) * 60 + sec;
                        m_state = M_COOK;
                    end
                end else if (key_valid && key_code < 10) begin
                    m_dig[3] = m_dig[2]; m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0];
                    m_dig[0] = int'(key_code);
                    m_state  = M_ENTRY;
                end
            end
            M_COOK: begin
                if (stop_clear || !door_closed) begin
                    m_state = M_PAUSE;
                end else if (sec_tick) begin
                    m_tot--;
                    if (m_tot == 0) begin
                        m_state = M_DONE; m_beeps = 0; clear_digits();
                    end
                end
            end
            M_PAUSE: begin
                if (stop_clear) begin
                    m_state = M_IDLE; clear_digits();
                end else if (start && door_closed) begin
                    m_state = M_COOK;
                end
            end
            default: begin
                if (stop_clear || key_valid) begin
                    m_state = M_IDLE;
                end else if (sec_tick) begin
                    m_beeps++;
                    if (m_beeps == 3) m_state = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, 32'(state_o), 32'(m_state));
        chk({tag, ".time"}, 32'(time_bcd), 32'(exp_time()));
        chk({tag, ".mag_on"}, 32'(mag_on), 32'(m_state == M_COOK));
        chk({tag, ".done_beep"}, 32'(done_beep), 32'(m_state == M_DONE));
    endtask

    task automatic cyc(input string tag, input logic st, input logic sp, input logic kv,
                       input logic [3:0] kc, input logic tk);
        start = st; stop_clear = sp; key_valid = kv; key_code = kc; sec_tick = tk;
        @(posedge clock);
        model_step();
        #1;
        start = 1'b0; stop_clear = 1'b0; key_valid = 1'b0; sec_tick = 1'b0;
        check_model(tag);
    endtask

    task automatic key(input logic [3:0] d);
        cyc("key", 1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    initial begin
        reset = 1'b1; door_closed = 1'b1;
        start = 1'b0; stop_clear = 1'b0; key_valid = 1'b0; key_code = 4'd0; sec_tick = 1'b0;
        m_state = M_IDLE; clear_digits(); m_tot = 0; m_beeps = 0;
        #2;
        cyc("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("reset_time", 32'(time_bcd), 32'h0);
        chk("reset_flags", 32'({state_o, mag_on, done_beep}), 32'h0);
        reset = 1'b0;

        key(4'd1); key(4'd3); key(4'd0);
        cyc("start130", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("plan_0130", 32'(time_bcd), 32'h0130);
        chk("plan_cook", 32'(state_o), 32'd2);
        cyc("tick129", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_0129", 32'(time_bcd), 32'h0129);
        cyc("stop1", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc("stop2", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        key(4'd1); key(4'd0); key(4'd0);
        cyc("start100", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc("tick059", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_0059", 32'(time_bcd), 32'h0059);
        cyc("stop1", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc("stop2", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        cyc("start1000", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc("tick959", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_0959", 32'(time_bcd), 32'h0959);
        cyc("stop1", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc("stop2", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        key(4'd9); key(4'd9);
        cyc("start99", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("plan_clamp", 32'(time_bcd), 32'h0059);
        chk("plan_clamp_cook", 32'(state_o), 32'd2);
        cyc("stop1", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc("stop2", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        key(4'd2);
        cyc("start002", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc("tick001", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        cyc("tick000", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_done", 32'({state_o, done_beep}), {28'h0, 3'd4, 1'b1});
        cyc("beep1", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        cyc("beep2", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_beep2", 32'(done_beep), 32'h1);
        cyc("beep3", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_beep_end", 32'({state_o, done_beep}), 32'h0);

        key(4'd4); key(4'd5);
        cyc("start045", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        door_closed = 1'b0;
        cyc("door_tick", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_pause", 32'({time_bcd, state_o, mag_on}), {12'h0, 16'h0045, 3'd3, 1'b0});
        door_closed = 1'b1;
        cyc("resume", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("plan_resume", 32'({state_o, mag_on}), {28'h0, 3'd2, 1'b1});
        cyc("stop1", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc("stop2", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("plan_cleared", 32'({time_bcd, state_o}), 32'h0);

        key(4'd5); key(4'd7); key(4'd1); key(4'd2); key(4'd3);
        chk("plan_7123", 32'(time_bcd), 32'h7123);
        door_closed = 1'b0;
        cyc("start_door_open", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("plan_door_ignored", 32'(state_o), 32'd1);
        door_closed = 1'b1;
        cyc("start7123", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc("tick7122", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_7122", 32'(time_bcd), 32'h7122);
        reset = 1'b1;
        cyc("mid_reset", 1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
        chk("plan_reset", 32'({time_bcd, state_o, mag_on, done_beep}), 32'h0);
        reset = 1'b0;

        key(4'd3);
        cyc("start003", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("stuck_tick", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("plan_stuck_done", 32'(state_o), 32'd4);

        for (int i = 0; i < 800; i++) begin
            door_closed = ($urandom_range(0, 9) != 0);
            reset       = ($urandom_range(0, 199) == 0);
            cyc("rand",
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 3) == 0,
                4'($urandom_range(0, 15)),
                $urandom_range(0, 2) == 0);
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
